// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display scan path.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned AN_W       = NUM_DIGITS;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam logic [AN_W-1:0] AN_ALL_OFF = 4'b1111;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts 0..CLK_DIV-1 and wraps, flagging the last count.
// Ports:
//   clk, rst  - clock, async active-high reset
//   count     - current prescaler value p
//   tick_c    - combinational slot tick, high while count == CLK_DIV-1
module scan_tick_gen #(
  parameter int unsigned CLK_DIV = 50000,
  localparam int unsigned CNT_W  = $clog2(CLK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] count,
  output logic             tick_c
);

  assign tick_c = (count == CNT_W'(CLK_DIV - 1));

  // Free-running prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick_c) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_display_scan.sv
// Time-multiplexed scan driver for a 4-digit 7-segment display.
// Latches a 16-bit value and error flag, cycles the active digit every
// CLK_DIV cycles with a BLANK_CYCLES all-off guard at the start of each slot,
// and applies leading-zero suppression (disabled while an error is shown).
// Ports:
//   clk, rst      - clock, async active-high reset
//   load          - capture value/error on this edge
//   value, error  - result and error flag to display
//   lz_en         - leading-zero suppression enable (used live)
//   hex_dig       - nibble for the decoder
//   blank, err    - decoder blank / "E" requests
//   an            - active-low digit anodes
module seg7_display_scan
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [VALUE_W-1:0]  value,
  input  logic                error,
  input  logic                lz_en,
  output logic [NIBBLE_W-1:0] hex_dig,
  output logic                blank,
  output logic                err,
  output logic [AN_W-1:0]     an
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0]    p;
  logic                tick_c;
  digit_t              d;
  logic [VALUE_W-1:0]  value_q;
  logic                err_q;

  logic                guard_c;
  logic [AN_W-1:0]     an_c;
  logic                blank_c;
  logic [NIBBLE_W-1:0] hex_c;
  logic                err_c;

  // True when nibble dd and every higher nibble of v are zero
  function automatic logic upper_zero(input logic [VALUE_W-1:0] v, input digit_t dd);
    return (v >> {dd, 2'b00}) == '0;
  endfunction

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .count  (p),
    .tick_c (tick_c)
  );

  // Shadow registers for the displayed result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      err_q   <= 1'b0;
    end else if (load) begin
      value_q <= value;
      err_q   <= error;
    end
  end

  // Active digit index, advanced once per slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= '0;
    end else if (tick_c) begin
      d <= d + DIGIT_W'(1);
    end
  end

  assign guard_c = (p < CNT_W'(BLANK_CYCLES));

  // Next output values; hex/err track the active digit even in the guard
  always_comb begin
    an_c    = AN_ALL_OFF;
    blank_c = 1'b1;
    hex_c   = value_q[{d, 2'b00} +: NIBBLE_W];
    err_c   = err_q;
    if (!guard_c) begin
      an_c    = ~(AN_W'(1) << d);
      blank_c = lz_en && !err_q && (d != '0) && upper_zero(value_q, d);
    end
  end

  // Registered decoder/anode outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an      <= AN_ALL_OFF;
      blank   <= 1'b1;
      err     <= 1'b0;
      hex_dig <= '0;
    end else begin
      an      <= an_c;
      blank   <= blank_c;
      err     <= err_c;
      hex_dig <= hex_c;
    end
  end

endmodule

// File: tb/tb_seg7_display_scan.sv
module tb_seg7_display_scan;

  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned BLANK   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        error = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  hex_dig;
  logic        blank;
  logic        err;
  logic [3:0]  an;

  int checks = 0;
  int errors = 0;

  // Behavioural model: cycles since reset release and latched content
  int          m_t = 0;
  logic [15:0] m_val = '0;
  logic        m_err = 1'b0;

  seg7_display_scan #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .value   (value),
    .error   (error),
    .lz_en   (lz_en),
    .hex_dig (hex_dig),
    .blank   (blank),
    .err     (err),
    .an      (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model + per-cycle compare
  always @(posedge clk) begin : model
    int p, d;
    logic [3:0] e_an, e_hex;
    logic e_blank, e_err, in_guard;
    if (rst) begin
      m_t = 0; m_val = '0; m_err = 1'b0;
      e_an = 4'hF; e_blank = 1'b1; e_hex = 4'h0; e_err = 1'b0; in_guard = 1'b0;
    end else begin
      p = m_t % CLK_DIV;
      d = (m_t / CLK_DIV) % 4;
      in_guard = (p < BLANK);
      e_hex = 4'((m_val >> (4 * d)) & 16'hF);
      e_err = m_err;
      if (in_guard) begin
        e_an = 4'hF; e_blank = 1'b1;
      end else begin
        e_an = 4'hF ^ 4'(1 << d);
        e_blank = lz_en && !m_err && d != 0 && ((m_val >> (4 * d)) == 0);
      end
      if (load) begin m_val = value; m_err = error; end
      m_t++;
    end
    #1;
    check("an", an, e_an);
    check("blank", blank, e_blank);
    if (!in_guard) begin
      check("hex_dig", hex_dig, e_hex);
      check("err", err, e_err);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until the anode pattern is seen, sampled after the edge
  task automatic wait_an(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #2;
      if (an == pat) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      errors++;
      $display("FAIL wait_an: pattern %b not seen, an=%b", pat, an);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic e);
    @(negedge clk);
    value = v; error = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin : stim
    bit ok;
    int n;
    // Reset state
    cycles(3);
    check("rst_an", an, 4'hF);
    check("rst_blank", blank, 1);
    check("rst_err", err, 0);
    check("rst_hex", hex_dig, 0);

    // Release: first digit-0 anode two edges later
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2; n++;
      if (an == 4'b1110) break;
    end
    check("first_low_edges", n, 2);
    n = 0;
    while (an == 4'b1110 && n < 40) begin @(posedge clk); #2; n++; end
    check("low_len", n, 7);
    // Period: next entry into digit 0 is 32 edges later
    n = 7;
    while (an != 4'b1110 && n < 80) begin @(posedge clk); #2; n++; end
    check("period", n, 32);

    // 1A3F with suppression off
    lz_en = 1'b0;
    do_load(16'h1A3F, 1'b0);
    wait_an(4'b1110, ok); if (ok) begin check("1A3F_d0", hex_dig, 4'hF); check("1A3F_b0", blank, 0); end
    wait_an(4'b1101, ok); if (ok) check("1A3F_d1", hex_dig, 4'h3);
    wait_an(4'b1011, ok); if (ok) check("1A3F_d2", hex_dig, 4'hA);
    wait_an(4'b0111, ok); if (ok) begin check("1A3F_d3", hex_dig, 4'h1); check("1A3F_b3", blank, 0); end

    // 0050 with suppression on
    lz_en = 1'b1;
    do_load(16'h0050, 1'b0);
    wait_an(4'b0111, ok); if (ok) check("0050_b3", blank, 1);
    wait_an(4'b1110, ok); if (ok) begin check("0050_d0", hex_dig, 0); check("0050_b0", blank, 0); end
    wait_an(4'b1101, ok); if (ok) begin check("0050_d1", hex_dig, 5); check("0050_b1", blank, 0); end
    wait_an(4'b1011, ok); if (ok) check("0050_b2", blank, 1);

    // 0000: only digit 0 lit
    do_load(16'h0000, 1'b0);
    wait_an(4'b1110, ok); if (ok) begin check("0000_b0", blank, 0); check("0000_d0", hex_dig, 0); end
    wait_an(4'b1101, ok); if (ok) check("0000_b1", blank, 1);

    // Error overrides suppression
    do_load(16'h0000, 1'b1);
    wait_an(4'b1011, ok); if (ok) begin check("err_e2", err, 1); check("err_b2", blank, 0); end
    wait_an(4'b0111, ok); if (ok) begin check("err_e3", err, 1); check("err_b3", blank, 0); end

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 3) == 0);
      value = 16'($urandom);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1) == 0) value = value & ~(16'hF << (4 * k));
      error = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
    end
    load = 1'b0; lz_en = 1'b0;

    // Load coinciding with a slot tick
    n = 0;
    while ((m_t % CLK_DIV) != CLK_DIV - 1 && n < 20) begin @(negedge clk); n++; end
    value = 16'h9999; error = 1'b0; load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(posedge clk); #2;
    check("tick_load_guard", an, 4'hF);
    @(posedge clk); #2;
    check("tick_load_hex", hex_dig, 4'h9);

    // Reset mid-slot blanks at once
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_blank", blank, 1);
    cycles(2);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2; n++;
      if (an == 4'b1110) break;
    end
    check("restart_edges", n, 2);
    check("restart_hex", hex_dig, 0);
    cycles(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: timeout, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
